// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART bridge: a 16-byte register window in front of a TX FIFO
// (drained by the transmitter) and an RX FIFO (filled by the receiver).
// Loads return data one cycle after the access. Full and empty decisions use
// start-of-cycle counts, so there is no bypass between push and pop.
module uart_mmio_fifo #(
    parameter logic [31:0] BASE_ADDR = 32'h80000000,
    parameter int          TX_DEPTH  = 8,
    parameter int          RX_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int TXW = $clog2(TX_DEPTH);
    localparam int RXW = $clog2(RX_DEPTH);
    localparam logic [TXW:0] TX_FULL = (TXW+1)'(TX_DEPTH);
    localparam logic [RXW:0] RX_FULL = (RXW+1)'(RX_DEPTH);

    logic [7:0]   tx_mem [TX_DEPTH];
    logic [7:0]   rx_mem [RX_DEPTH];
    logic [TXW-1:0] tx_wp, tx_rp;
    logic [RXW-1:0] rx_wp, rx_rp;
    logic [TXW:0] tx_cnt;
    logic [RXW:0] rx_cnt;
    logic         tx_drop;

    logic load_op, store_op;
    logic hit_stat, hit_rxd, hit_txd, hit_clr, load_hit;
    logic tx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop, drop_set, drop_clr;
    logic [31:0] load_val;
    logic unused_wdata;

    // A simultaneous load and store is treated as no access at all.
    assign load_op  = is_load & ~is_store;
    assign store_op = is_store & ~is_load;

    assign hit_stat = (addr == BASE_ADDR);
    assign hit_rxd  = (addr == BASE_ADDR + 32'h4);
    assign hit_txd  = (addr == BASE_ADDR + 32'h8);
    assign hit_clr  = (addr == BASE_ADDR + 32'hC);
    assign load_hit = load_op & (hit_stat | hit_rxd | hit_txd | hit_clr);

    assign tx_full  = (tx_cnt == TX_FULL);
    assign rx_empty = (rx_cnt == '0);

    assign tx_valid = (tx_cnt != '0);
    assign tx_data  = tx_mem[tx_rp];
    assign rx_ready = (rx_cnt != RX_FULL);

    assign tx_push  = store_op & hit_txd & ~tx_full;
    assign drop_set = store_op & hit_txd & tx_full;
    assign drop_clr = store_op & hit_clr & wdata[2];
    assign tx_pop   = tx_valid & tx_ready;
    assign rx_push  = rx_valid & rx_ready;
    assign rx_pop   = load_op & hit_rxd & ~rx_empty;

    assign unused_wdata = ^{wdata[31:8], wdata[1:0]};

    // Select the load return value from start-of-cycle state.
    always_comb begin
        load_val = 32'h0;
        if (hit_stat) begin
            load_val = {8'h00, 8'(rx_cnt), 8'(tx_cnt), 5'h00, tx_drop, ~rx_empty, ~tx_full};
        end else if (hit_rxd && !rx_empty) begin
            load_val = {24'h0, rx_mem[rx_rp]};
        end
    end

    // Registered load response; rdata holds between hits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata       <= 32'h0;
            rdata_valid <= 1'b0;
        end else begin
            rdata_valid <= load_hit;
            if (load_hit) rdata <= load_val;
        end
    end

    // TX pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_wp   <= '0;
            tx_rp   <= '0;
            tx_cnt  <= '0;
            tx_drop <= 1'b0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + 1'b1;
            else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - 1'b1;
            if (drop_set)      tx_drop <= 1'b1;
            else if (drop_clr) tx_drop <= 1'b0;
        end
    end

    // RX pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + 1'b1;
            else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - 1'b1;
        end
    end

    // FIFO storage is deliberately not reset; writes are blocked in reset.
    always_ff @(posedge clk) begin
        if (rst_n && tx_push) tx_mem[tx_wp] <= wdata[7:0];
        if (rst_n && rx_push) rx_mem[rx_wp] <= rx_data;
    end

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Self-checking bench for uart_mmio_fifo: table-driven vectors, directed
// corner sequences, randomized traffic against a queue-based model, and a
// second small-depth instance for pointer wrap and mid-operation reset.
module tb_uart_mmio_fifo;

    localparam logic [31:0] BASE = 32'h80000000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // default-depth instance
    logic        rst_n, is_load, is_store, tx_ready, rx_valid;
    logic [31:0] addr, wdata, rdata;
    logic        rdata_valid, tx_valid, rx_ready;
    logic [7:0]  tx_data, rx_data;

    // depth-4 instance
    logic        q_rst_n, q_is_load, q_is_store, q_tx_ready, q_rx_valid;
    logic [31:0] q_addr, q_wdata, q_rdata;
    logic        q_rdata_valid, q_tx_valid, q_rx_ready;
    logic [7:0]  q_tx_data, q_rx_data;

    uart_mmio_fifo #(.BASE_ADDR(BASE), .TX_DEPTH(8), .RX_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .is_load(is_load), .is_store(is_store),
        .addr(addr), .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    uart_mmio_fifo #(.BASE_ADDR(BASE), .TX_DEPTH(4), .RX_DEPTH(4)) dut4 (
        .clk(clk), .rst_n(q_rst_n), .is_load(q_is_load), .is_store(q_is_store),
        .addr(q_addr), .wdata(q_wdata), .rdata(q_rdata), .rdata_valid(q_rdata_valid),
        .tx_data(q_tx_data), .tx_valid(q_tx_valid), .tx_ready(q_tx_ready),
        .rx_data(q_rx_data), .rx_valid(q_rx_valid), .rx_ready(q_rx_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: byte queues plus the sticky flag and load response.
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    bit          m_drop;
    logic [31:0] m_rdata;
    bit          m_rv;

    task automatic model_step();
        int tn, rn, k;
        bit ld, st;
        if (!rst_n) begin
            tx_q.delete(); rx_q.delete();
            m_drop = 0; m_rdata = 0; m_rv = 0;
            return;
        end
        tn = tx_q.size(); rn = rx_q.size();
        ld = is_load && !is_store;
        st = is_store && !is_load;
        k = -1;
        for (int j = 0; j < 4; j++) if (addr == BASE + 32'(4 * j)) k = j;
        if (ld && k >= 0) begin
            m_rv = 1;
            case (k)
                0: m_rdata = {8'h00, 8'(rn), 8'(tn), 5'h0, m_drop, rn != 0, tn < 8};
                1: m_rdata = (rn != 0) ? {24'h0, rx_q[0]} : 32'h0;
                default: m_rdata = 32'h0;
            endcase
        end else begin
            m_rv = 0;
        end
        if (tn != 0 && tx_ready) void'(tx_q.pop_front());
        if (st && k == 2) begin
            if (tn < 8) tx_q.push_back(wdata[7:0]);
            else m_drop = 1;
        end
        if (st && k == 3 && wdata[2]) m_drop = 0;
        if (ld && k == 1 && rn != 0) void'(rx_q.pop_front());
        if (rx_valid && rn < 8) rx_q.push_back(rx_data);
    endtask

    task automatic model_cmp();
        chk("m_rdata", rdata, m_rdata);
        chk("m_rdata_valid", {31'h0, rdata_valid}, {31'h0, m_rv});
        chk("m_tx_valid", {31'h0, tx_valid}, {31'h0, tx_q.size() != 0});
        if (tx_q.size() != 0) chk("m_tx_data", {24'h0, tx_data}, {24'h0, tx_q[0]});
        chk("m_rx_ready", {31'h0, rx_ready}, {31'h0, rx_q.size() != 8});
    endtask

    task automatic step();
        model_step();
        tick();
        model_cmp();
    endtask

    task automatic bus(input bit ld, input bit st, input logic [31:0] a, input logic [31:0] wd);
        is_load = ld; is_store = st; addr = a; wdata = wd;
    endtask

    typedef struct {
        bit          ld;
        bit          st;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rdata;
        bit          exp_rv;
    } vec_t;

    vec_t vecs[17];

    int ntx, nrx;

    initial begin
        // table: reset status, TX overflow, status readback, clear, no-op cases
        vecs[0] = '{1, 0, BASE, 0, 32'h1, 1};
        for (int i = 0; i < 9; i++) vecs[1 + i] = '{0, 1, BASE + 8, 32'hFFFFFF41 + i, 32'h1, 0};
        vecs[10] = '{1, 0, BASE,          0, 32'h804, 1};
        vecs[11] = '{1, 0, BASE + 8,      0, 32'h0,   1};
        vecs[12] = '{0, 1, BASE + 32'hC,  4, 32'h0,   0};
        vecs[13] = '{1, 0, BASE,          0, 32'h800, 1};
        vecs[14] = '{0, 0, BASE,          0, 32'h800, 0};
        vecs[15] = '{1, 1, BASE + 4,      0, 32'h800, 0};
        vecs[16] = '{1, 0, BASE + 32'h10, 0, 32'h800, 0};

        bus(0, 0, 0, 0);
        tx_ready = 0; rx_valid = 0; rx_data = 0;
        q_rst_n = 0; q_is_load = 0; q_is_store = 0; q_addr = 0; q_wdata = 0;
        q_tx_ready = 0; q_rx_valid = 0; q_rx_data = 0;

        rst_n = 0;
        step();
        chk("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("reset_rx_ready", {31'h0, rx_ready}, 32'h1);
        rst_n = 1;

        foreach (vecs[i]) begin
            bus(vecs[i].ld, vecs[i].st, vecs[i].a, vecs[i].wd);
            step();
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_rv", i), {31'h0, rdata_valid}, {31'h0, vecs[i].exp_rv});
        end
        bus(0, 0, 0, 0);

        // drain TX: 0x41..0x48 in order, then empty
        tx_ready = 1;
        for (int i = 0; i < 8; i++) begin
            chk("tx_drain_data", {24'h0, tx_data}, 32'h41 + i);
            step();
        end
        chk("tx_drain_empty", {31'h0, tx_valid}, 32'h0);
        tx_ready = 0;

        // fill RX to full; ninth byte held off
        for (int i = 0; i < 8; i++) begin
            rx_valid = 1; rx_data = 8'h10 + 8'(i);
            step();
        end
        chk("rx_full_ready", {31'h0, rx_ready}, 32'h0);
        rx_data = 8'h18;
        step(); step();
        rx_valid = 0;
        for (int i = 0; i < 9; i++) begin
            bus(1, 0, BASE + 4, 0);
            step();
            chk("rx_read", rdata, (i < 8) ? 32'h10 + i : 32'h0);
            chk("rx_read_rv", {31'h0, rdata_valid}, 32'h1);
        end

        // same-cycle RX push and data load on empty FIFO
        rx_valid = 1; rx_data = 8'h55;
        step();
        chk("rx_nobypass", rdata, 32'h0);
        rx_valid = 0;
        step();
        chk("rx_after", rdata, 32'h55);

        // full TX with concurrent pop and store: store dropped
        for (int i = 0; i < 8; i++) begin
            bus(0, 1, BASE + 8, 32'h60 + i);
            step();
        end
        tx_ready = 1;
        bus(0, 1, BASE + 8, 32'h70);
        step();
        tx_ready = 0;
        bus(1, 0, BASE, 0);
        step();
        chk("drop_status", rdata, 32'h705);
        bus(0, 1, BASE + 32'hC, 32'h4);
        step();
        bus(1, 0, BASE, 0);
        step();
        chk("clear_status", rdata, 32'h701);
        bus(0, 0, 0, 0);
        tx_ready = 1;
        for (int i = 0; i < 8; i++) step();

        // randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            int sel;
            sel = $urandom_range(0, 5);
            is_load  = ($urandom_range(0, 2) == 0);
            is_store = ($urandom_range(0, 1) == 0);
            addr = (sel < 4) ? BASE + 32'(4 * sel) : (sel == 4) ? BASE + 32'h10 : BASE + 1;
            wdata = $urandom;
            tx_ready = ($urandom_range(0, 2) == 0);
            rx_valid = ($urandom_range(0, 1) == 0);
            rx_data = 8'($urandom);
            rst_n = ($urandom_range(0, 149) != 0);
            step();
        end
        rst_n = 1;
        bus(0, 0, 0, 0);

        // depth-4 instance: sustained TX push/pop with wrap
        q_rst_n = 1;
        q_tx_ready = 1;
        ntx = 0;
        for (int k = 0; k < 22; k++) begin
            q_is_store = (k < 20); q_addr = BASE + 8; q_wdata = 32'hA0 + k;
            if (q_tx_valid) begin
                chk("q_tx_order", {24'h0, q_tx_data}, 32'hA0 + ntx);
                ntx++;
            end
            tick();
        end
        chk("q_tx_count", ntx, 20);
        q_is_store = 0;

        // depth-4 instance: sustained RX push/pop with wrap
        nrx = 0;
        for (int k = 0; k < 22; k++) begin
            q_rx_valid = (k < 20); q_rx_data = 8'hC0 + 8'(k);
            q_is_load = (k >= 1 && k <= 20); q_addr = BASE + 4;
            tick();
            if (q_rdata_valid) begin
                chk("q_rx_order", q_rdata, 32'hC0 + nrx);
                nrx++;
            end
        end
        chk("q_rx_count", nrx, 20);
        q_is_load = 0; q_rx_valid = 0;

        // mid-operation reset with 3 bytes queued each way
        q_tx_ready = 0;
        for (int k = 0; k < 3; k++) begin
            q_is_store = 1; q_wdata = 32'hE0 + k; q_addr = BASE + 8;
            q_rx_valid = 1; q_rx_data = 8'hF0 + 8'(k);
            tick();
        end
        q_is_store = 0; q_rx_valid = 0;
        chk("q_pre_reset_tx_valid", {31'h0, q_tx_valid}, 32'h1);
        q_rst_n = 0; q_tx_ready = 1; q_rx_valid = 1;
        tick();
        chk("q_reset_tx_valid", {31'h0, q_tx_valid}, 32'h0);
        chk("q_reset_rx_ready", {31'h0, q_rx_ready}, 32'h1);
        chk("q_reset_rdata_valid", {31'h0, q_rdata_valid}, 32'h0);
        q_rst_n = 1; q_tx_ready = 0; q_rx_valid = 0;
        q_is_load = 1; q_addr = BASE;
        tick();
        chk("q_reset_status", q_rdata, 32'h1);
        q_addr = BASE + 4;
        tick();
        chk("q_reset_rx_empty", q_rdata, 32'h0);
        q_is_load = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_mmio_fifo.md
# uart_mmio_fifo

Memory-mapped UART bridge sitting between the core's load/store datapath and the UART transmitter/receiver. It buffers outgoing and incoming bytes in parametrised TX and RX FIFOs and exposes status, occupancy and sticky error bits. Loads return data with registered one-cycle latency, so the core can run UART polling loops without stalling on the serial line.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h80000000: base of the 16-byte register window.
- `TX_DEPTH`, default 8: TX FIFO entries. Power of two, 2..128.
- `RX_DEPTH`, default 8: RX FIFO entries. Power of two, 2..128.

Ports:
- `clk`  in  1  single clock. All state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `is_load`  in  1  the current MEM-stage instruction is a load.
- `is_store`  in  1  the current MEM-stage instruction is a store.
- `addr`  in  32  byte address from the ALU.
- `wdata`  in  32  store data (forwarded rs2).
- `rdata`  out  32  registered load data.
- `rdata_valid`  out  1  high for exactly the cycle after a load hit the window.
- `tx_data`  out  8  byte offered to the UART transmitter.
- `tx_valid`  out  1  TX FIFO non-empty.
- `tx_ready`  in  1  transmitter accepts `tx_data`.
- `rx_data`  in  8  byte from the UART receiver.
- `rx_valid`  in  1  receiver holds a byte.
- `rx_ready`  out  1  RX FIFO not full.

## Operation
- A hit requires a full 32-bit match of `addr` with one of the offsets below.
  - If `is_load` and `is_store` are both high, the cycle is a no-op.
  - Non-hit addresses cause no state change, and `rdata` holds its value.
- Offset 0x0, load (status). Returns:
  - bit0 = TX not full
  - bit1 = RX not empty
  - bit2 = tx_drop sticky bit
  - bits[15:8] = TX count
  - bits[23:16] = RX count
  - all other bits 0
  - All fields are sampled before this cycle's updates.
- Offset 0x4, load (RX data). If the RX FIFO is non-empty, pops the head and returns {24'b0, byte}. If empty, returns 0 and does not pop.
- Offset 0x8, store (TX data). If TX count < TX_DEPTH at the start of the cycle, pushes `wdata[7:0]`. Otherwise the byte is dropped and tx_drop is set.
- Offset 0xC, store (clear). `wdata[2]`=1 clears tx_drop. A set and a clear in the same cycle cannot occur, because they come from different offsets.
- Loads to offsets 0x8 and 0xC return 0. Stores to offsets 0x0 and 0x4 have no effect.
- TX drain: `tx_valid` = (TX count != 0) and `tx_data` = FIFO head, both from registers. A pop occurs on `tx_valid && tx_ready`.
- RX fill: `rx_ready` = (RX count != RX_DEPTH), from registers. A push occurs on `rx_valid && rx_ready`.
- FIFOs:
  - Circular buffers with log2(DEPTH)-bit pointers that wrap naturally.
  - Counts are log2(DEPTH)+1 bits wide.
  - A push and a pop in the same cycle leave the count unchanged.
- Full/empty decisions use start-of-cycle counts. There is no bypass:
  - A push to a full FIFO is refused even if a pop occurs that cycle.
  - A pop from an empty FIFO is refused even if a push occurs that cycle.

## Timing
- Reset (`rst_n`=0 at a clock edge):
  - pointers and counts = 0
  - tx_drop = 0
  - `rdata` = 0, `rdata_valid` = 0
  - therefore `tx_valid` = 0 and `rx_ready` = 1
  - FIFO storage contents are not reset.
- Reset mid-operation discards all buffered bytes. A handshake in the reset cycle is not counted.
- Load latency is 1 cycle:
  - A load hit in cycle N gives `rdata` and `rdata_valid`=1 in N+1.
  - `rdata_valid` returns to 0 in N+2 unless another hit occurs.
  - Back-to-back loads are supported at one per cycle.
- A store push in cycle N makes `tx_valid` high from N+1, with `tx_data` = that byte if the FIFO was empty.
- An `rx_valid` push in cycle N is visible to a status or data load issued in N+1.
- The TX pop and RX push handshakes sustain one byte per cycle each, concurrently with MMIO accesses.

## Test plan
- Reset, then load 0x0 → next cycle `rdata`=32'h00000001, `rdata_valid`=1; `tx_valid`=0, `rx_ready`=1.
- With `tx_ready`=0, store 0x41..0x49 (9 bytes) to 0x80000008:
  - status = 32'h00000804 (TX count 8, tx_drop set, TX full).
  - Then raise `tx_ready` → `tx_data` sequence 0x41..0x48, then `tx_valid`=0.
- Drive 8 RX bytes 0x10..0x17 → `rx_ready`=0 and an asserted ninth `rx_valid` is held off. Eight loads of 0x80000004 return 0x10..0x17. A ninth load returns 0 with `rdata_valid`=1.
- RX FIFO empty; in the same cycle push 0x55 on RX and load 0x4 → returns 0. The next load returns 0x55.
- TX full with `tx_ready`=1 and a store in the same cycle → store dropped, tx_drop=1, count becomes 7. Store 32'h4 to 0x8000000C → tx_drop=0.
- TX_DEPTH=RX_DEPTH=4 instance: 20 sustained push/pop pairs through both FIFOs → pointer wrap preserves order; assert `rst_n`=0 with 3 bytes queued → counts 0 and `tx_valid`=0 on the next cycle.
